// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx between NUM_REQ sources.
// A grant is held until the owner's last byte; a one-cycle HOLD follows every byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int NUM_BITS  = 8,
  parameter int MAX_BYTES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_byte,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_BITS-1:0]          tx_byte,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         overrun,
  output logic                         abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_gidx;
  logic [IW-1:0]      r_last_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overrun;
  logic               r_abort;

  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_cand;
  logic               w_found;
  logic               w_own_req;
  logic               w_xfer;
  logic               w_release;
  logic               w_set_over;
  logic               w_set_abort;

  // Scan upward from last_ptr+1 with wrap; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IW'((int'(r_last_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_own_req = req[r_gidx];
  assign tx_valid  = (r_state == S_SEND) & req_valid[r_gidx] & w_own_req;
  assign tx_byte   = (r_state == S_SEND) ? req_byte[int'(r_gidx)*NUM_BITS +: NUM_BITS] : '0;
  assign w_xfer    = tx_valid & tx_ready;
  assign req_ready = w_xfer ? r_grant : '0;
  assign grant     = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign abort     = r_abort;

  always_comb begin
    w_release   = 1'b0;
    w_set_over  = 1'b0;
    w_set_abort = 1'b0;
    if (r_state == S_SEND) begin
      if (!w_own_req) begin
        w_release   = 1'b1;
        w_set_abort = 1'b1;
      end else if (w_xfer) begin
        if (req_last[r_gidx]) begin
          w_release = 1'b1;
        end else if ((r_count + CW'(1)) == CW'(MAX_BYTES)) begin
          w_release  = 1'b1;
          w_set_over = 1'b1;
        end
      end
    end else if (r_state == S_HOLD && !w_own_req) begin
      w_release = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_last_ptr <= IW'(NUM_REQ - 1);
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_overrun <= w_set_over;
      r_abort   <= w_set_abort;
      if (r_state == S_SEND && w_xfer) r_count <= r_count + CW'(1);
      if (w_release) begin
        r_grant    <= '0;
        r_last_ptr <= r_gidx;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_found) begin
              r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
              r_gidx  <= w_win;
              r_count <= '0;
              r_state <= S_SEND;
            end
          end
          S_SEND:  if (w_xfer) r_state <= S_HOLD;
          S_HOLD:  r_state <= S_SEND;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, message-granular arbiter that shares the single `uart_tx` byte transmitter between `NUM_REQ` message sources, such as the temperature formatter, a status/debug reporter and an error reporter. It sits between the requesters and `uart_tx`. It grants one requester at a time, forwards that requester's bytes with a valid/ready handshake, and holds the grant until the message's last byte is sent. Each transferred byte is followed by a guard cycle so that `uart_tx` never sees a stale valid.

## Interface

Parameters:

- `NUM_REQ`, default 3: number of requesters; legal range 2–8.
- `NUM_BITS`, default 8: byte width.
- `MAX_BYTES`, default 32: maximum number of bytes per grant before a forced release.

Ports:

- `clk`, in, 1: system clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, `NUM_REQ`: requester i wants the transmitter; held high for the whole message.
- `req_byte`, in, `NUM_REQ*NUM_BITS`: byte of requester i occupies bits `[i*NUM_BITS +: NUM_BITS]`.
- `req_valid`, in, `NUM_REQ`: `req_byte` of requester i is valid.
- `req_last`, in, `NUM_REQ`: the current byte of requester i is the final byte of its message.
- `req_ready`, out, `NUM_REQ`: the byte of requester i is consumed this cycle.
- `grant`, out, `NUM_REQ`: registered one-hot current owner; all-zero when idle.
- `tx_byte`, out, `NUM_BITS`: byte to `uart_tx`.
- `tx_valid`, out, 1: `tx_byte` is valid; connects to the `uart_tx` data-valid input.
- `tx_ready`, in, 1: `uart_tx` is idle and can accept a byte.
- `busy`, out, 1: a grant is active.
- `overrun`, out, 1: one-cycle pulse when a grant is force-released at `MAX_BYTES`.
- `abort`, out, 1: one-cycle pulse when the owner drops `req` before its last byte.

## Operation

- **State machine:** three states, IDLE, SEND and HOLD.
  - Internal `last_ptr` holds the most recently served index.
  - Internal `count` is a byte counter of width `$clog2(MAX_BYTES+1)`.
- **IDLE:**
  - `grant` = 0.
  - If `req` is non-zero, the winner is the first set bit scanning upward from `(last_ptr+1) mod NUM_REQ`, wrapping around.
  - On the next edge: `grant` ← one-hot winner, `count` ← 0, state → SEND.
- **SEND:**
  - `tx_byte` = `req_byte[g]`.
  - `tx_valid` = `req_valid[g] & req[g]`.
  - `req_ready[g]` = `tx_valid & tx_ready`; all other `req_ready` bits are 0.
- **Transfer:** a transfer occurs when `tx_valid & tx_ready`. On a transfer, `count` increments, then:
  - if `req_last[g]`, release;
  - else if `count+1 == MAX_BYTES`, release and pulse `overrun`;
  - otherwise state → HOLD.
- **Owner drops out:**
  - If `req[g]` is 0 in SEND, release and pulse `abort`; no byte is issued that cycle.
  - If `req[g]` is 0 in HOLD, release without `abort`.
- **HOLD:**
  - `tx_valid` = 0 and all `req_ready` = 0 for exactly one cycle.
  - State → SEND. This covers the one-cycle lag before `uart_tx` drops `tx_ready` after accepting a byte.
- **Release:** on the next edge, `grant` ← 0, `last_ptr` ← g, state → IDLE.
- **Outside SEND:** `tx_byte` = 0 and `tx_valid` = 0.
- **Other combinational outputs:** `busy` = (state != IDLE).
- **Requests arriving during a grant:** these are ignored until the grant is released; no preemption.
- **Simultaneous requests in IDLE:** round-robin priority only. Each requester is served at most once per `NUM_REQ` grants while others wait.

## Timing

- **Reset values:**
  - state IDLE;
  - `grant` = 0, `count` = 0, `last_ptr` = `NUM_REQ-1`, so requester 0 has first priority;
  - `tx_valid` = 0, `tx_byte` = 0, `req_ready` = 0;
  - `busy` = 0, `overrun` = 0, `abort` = 0.
- **Reset mid-message:** the message is dropped. `tx_valid` goes low asynchronously and there is no partial completion; requesters must restart.
- **Arbitration latency:** `req` rising in IDLE at edge N gives `grant` and SEND at edge N+1. `tx_valid` can first be high in the cycle after edge N+1.
- **Byte cadence:** at most one transfer per 2 cycles (SEND + HOLD); the actual rate is limited by `uart_tx`.
- **Turnaround:** release gives IDLE for ≥1 cycle (`grant` = 0) before the next grant. Minimum message-to-message gap is 1 idle cycle plus 1 arbitration cycle.
- **Pulse timing:** `overrun` and `abort` are registered; each is high for the single cycle following the release edge.
- **Output paths:** `tx_byte`, `tx_valid` and `req_ready` are combinational from the registered `grant`/state and the requester inputs. There is no combinational path from `tx_ready` to `tx_valid`.

## Test plan

- **Single requester:** reset, then `NUM_REQ`=3 and `req[0]` sends 4 bytes 0x54,0x65,0x6D,0x0A with `last` on the 4th, against a `uart_tx` model → `grant`=001, the 4 bytes appear in order, one HOLD cycle after each, then `grant`=000 and `last_ptr`=0.
- **Simultaneous requests:** `req`=111 held continuously, each message 2 bytes → grant order 001, 010, 100, 001, with 1 IDLE cycle between grants.
- **Forced release:** `MAX_BYTES`=4 and `req[1]` streams with `last` never set → exactly 4 transfers, `overrun` pulses once, grant released, `last_ptr`=1.
- **Abort:** `req[2]` drops after 2 of 5 bytes → `abort` pulse, no further `tx_valid`, IDLE; a pending `req[0]` is granted next.
- **Reset mid-message:** assert `reset` during byte 3 → `tx_valid`=0 and `grant`=0 immediately. After release, `req`=110 grants requester 1 first, since reset restored `last_ptr`=2.
